// File: rtl/avg_pooling_layer.sv
// 2x2 stride-2 average pooling over a parallel IMG_W x IMG_H signed map, one window per enabled clock.
// Optional AVG_POOL_ROUND_EN: round half up (sum+2)>>>2 instead of floor sum>>>2.
module avg_pooling_layer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [IN_W-1:0]  img  [IMG_W*IMG_H],
  output logic                    finished_pool,
  output logic signed [OUT_W-1:0] pool [(IMG_W/2)*(IMG_H/2)]
);

  localparam int PW    = IMG_W / 2;
  localparam int PH    = IMG_H / 2;
  localparam int N_IN  = IMG_W * IMG_H;
  localparam int N_OUT = PW * PH;
  localparam int CW    = (PW > 1) ? $clog2(PW) : 1;
  localparam int RW    = (PH > 1) ? $clog2(PH) : 1;
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SW    = IN_W + 2;

`ifdef AVG_POOL_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(2);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        pcol;
  logic [RW-1:0]        prow;
  logic [KW-1:0]        k;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] avg;

  always_comb begin
    // NOTE: every variable assigned here gets a value first, so no latch can be inferred.
    sum = '0;
    k   = KW'(int'(prow) * PW + int'(pcol));
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        sum = sum + SW'(img[IW'((2 * int'(prow) + dr) * IMG_W + 2 * int'(pcol) + dc)]);
      end
    end
    // Four IN_W values plus the rounding bias always fit in IN_W+2 bits.
    avg = (sum + RND) >>> 2;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      finished_pool <= 1'b0;
      pcol          <= '0;
      prow          <= '0;
      // NOTE: the output map is reset deliberately; downstream must see zeros, not stale data, after reset.
      for (int i = 0; i < N_OUT; i++) pool[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state         <= RUN;
            finished_pool <= 1'b0;
          end
        end
        RUN: begin
          if (enable) begin
            pool[k] <= OUT_W'(avg);
            if (pcol == CW'(PW - 1)) begin
              pcol <= '0;
              if (prow == RW'(PH - 1)) begin
                prow          <= '0;
                state         <= DONE;
                finished_pool <= 1'b1;
              end else begin
                prow <= prow + RW'(1);
              end
            end else begin
              pcol <= pcol + CW'(1);
            end
          end
        end
        DONE: begin
          if (!enable) begin
            state         <= IDLE;
            finished_pool <= 1'b0;
            pcol          <= '0;
            prow          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_pooling_layer.sv
// Self-checking bench for avg_pooling_layer: directed window table, randomized runs against an
// arithmetic reference, pause, DONE hold and asynchronous mid-run reset.
module tb_avg_pooling_layer;

  localparam int W     = 28;
  localparam int H     = 28;
  localparam int N_IN  = W * H;
  localparam int PW    = W / 2;
  localparam int N_OUT = PW * (H / 2);

`ifdef AVG_POOL_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic signed [7:0]  img  [N_IN];
  logic              finished_pool;
  logic signed [15:0] pool [N_OUT];

  int checks   = 0;
  int failures = 0;
  int model_pool [N_OUT];
  int cur_k;

  typedef struct {
    string name;
    int    widx;
    int    v0, v1, v2, v3;
    int    exp_floor;
    int    exp_round;
  } vec_t;

  vec_t tbl [8];

  avg_pooling_layer #(.IMG_W(W), .IMG_H(H), .IN_W(8), .OUT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .img          (img),
    .finished_pool(finished_pool),
    .pool         (pool)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int elem_idx(input int k, input int dr, input int dc);
    return (2 * (k / PW) + dr) * W + 2 * (k % PW) + dc;
  endfunction

  // Reference: mean of the 2x2 window, floored (optionally after a +2 bias), in plain integers.
  function automatic int win_avg(input int k);
    int s = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        s += int'(img[elem_idx(k, dr, dc)]);
    if (ROUND) s += 2;
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    int nbad = 0;
    int first = -1;
    for (int k = 0; k < N_OUT; k++) begin
      if (int'(pool[k]) != model_pool[k]) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    check($sformatf("%s_mismatches(first_k=%0d)", tag, first), nbad, 0);
  endtask

  task automatic set_window(input int k, input int a, input int b, input int c, input int d);
    img[elem_idx(k, 0, 0)] = 8'(a);
    img[elem_idx(k, 0, 1)] = 8'(b);
    img[elem_idx(k, 1, 0)] = 8'(c);
    img[elem_idx(k, 1, 1)] = 8'(d);
  endtask

  task automatic randomize_img();
    for (int i = 0; i < N_IN; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic start_run();
    enable = 1'b1;
    step();
    cur_k = 0;
    check("start_finished_low", int'(finished_pool), 0);
  endtask

  // n enabled edges in RUN; with fine set, also checks each window lands on its own edge only.
  task automatic run_edges(input int n, input bit fine);
    for (int i = 0; i < n; i++) begin
      enable = 1'b1;
      step();
      model_pool[cur_k] = win_avg(cur_k);
      if (fine) begin
        check($sformatf("win_update_k%0d", cur_k), int'(pool[cur_k]), model_pool[cur_k]);
        if (cur_k + 1 < N_OUT)
          check($sformatf("win_ahead_hold_k%0d", cur_k + 1), int'(pool[cur_k + 1]), model_pool[cur_k + 1]);
        check($sformatf("finished_k%0d", cur_k), int'(finished_pool), int'(cur_k == N_OUT - 1));
      end
      cur_k++;
    end
  endtask

  task automatic back_to_idle(input string tag);
    enable = 1'b0;
    step();
    check({tag, "_idle_finished"}, int'(finished_pool), 0);
    check_all({tag, "_retain"});
  endtask

  initial begin
    tbl[0] = '{"win0_max",      0,  127,  127,  127,  127, 127,  127};
    tbl[1] = '{"win195_min",  195, -128, -128, -128, -128, -128, -128};
    tbl[2] = '{"win1_neg1",     1,   -1,    0,    0,    0,  -1,    0};
    tbl[3] = '{"win2_three",    2,    3,    0,    0,    0,   0,    1};
    tbl[4] = '{"win14_rowwrap",14,   10,   20,   30,   40,  25,   25};
    tbl[5] = '{"win13_lastcol",13, -128,  127, -128,  127,  -1,    0};
    tbl[6] = '{"win50_mixed",  50,    1,    1,    1,   -1,   0,    1};
    tbl[7] = '{"win120_neg3", 120,   -2,   -1,    0,    0,  -1,   -1};

    reset  = 1'b0;
    enable = 1'b0;
    cur_k  = 0;
    for (int i = 0; i < N_IN; i++) img[i] = '0;
    for (int k = 0; k < N_OUT; k++) model_pool[k] = 0;
    #12;
    check("reset_finished", int'(finished_pool), 0);
    check_all("reset_pool");
    @(negedge clk);
    reset = 1'b1;
    step();

    // All-zero map: finished must not rise before the last window.
    start_run();
    run_edges(N_OUT - 1, 1'b0);
    check("zero_finished_at_195", int'(finished_pool), 0);
    run_edges(1, 1'b0);
    check("zero_finished_at_196", int'(finished_pool), 1);
    check_all("zero_run");
    back_to_idle("zero");

    // Directed window table.
    for (int i = 0; i < N_IN; i++) img[i] = '0;
    for (int t = 0; t < 8; t++) set_window(tbl[t].widx, tbl[t].v0, tbl[t].v1, tbl[t].v2, tbl[t].v3);
    start_run();
    run_edges(N_OUT, 1'b0);
    check("table_finished", int'(finished_pool), 1);
    for (int t = 0; t < 8; t++)
      check(tbl[t].name, int'(pool[tbl[t].widx]), ROUND ? tbl[t].exp_round : tbl[t].exp_floor);
    check_all("table_all");

    // Enable held in DONE: no recompute even if img changes.
    randomize_img();
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1;
      step();
    end
    check("done_hold_finished", int'(finished_pool), 1);
    check_all("done_hold");
    back_to_idle("table");

    // Randomized runs with per-edge latency checks.
    for (int r = 0; r < 2; r++) begin
      randomize_img();
      start_run();
      run_edges(N_OUT, 1'b1);
      check_all($sformatf("rand%0d", r));
      back_to_idle($sformatf("rand%0d", r));
    end

    // Pause for 5 cycles after 50 enabled windows.
    randomize_img();
    start_run();
    run_edges(50, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("pause_hold_%0d", i), int'(pool[50]), model_pool[50]);
      check($sformatf("pause_finished_%0d", i), int'(finished_pool), 0);
    end
    run_edges(N_OUT - 51, 1'b0);
    check("pause_finished_early", int'(finished_pool), 0);
    run_edges(1, 1'b0);
    check("pause_finished_total", int'(finished_pool), 1);
    check_all("pause_run");
    back_to_idle("pause");

    // Asynchronous reset in the middle of a run, then a full rerun with a changed img[0].
    randomize_img();
    start_run();
    run_edges(100, 1'b0);
    img[0] = 8'sd8;
    #2;
    reset = 1'b0;
    #1;
    for (int k = 0; k < N_OUT; k++) model_pool[k] = 0;
    check("async_reset_finished", int'(finished_pool), 0);
    check_all("async_reset_pool");
    @(negedge clk);
    reset = 1'b1;
    start_run();
    run_edges(N_OUT - 1, 1'b0);
    check("rerun_finished_early", int'(finished_pool), 0);
    run_edges(1, 1'b0);
    check("rerun_finished", int'(finished_pool), 1);
    check("rerun_pool0", int'(pool[0]), win_avg(0));
    check_all("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
